// File: rtl/axil_chk_pkg.sv
// Shared error indices and helpers for the AXI4-lite protocol checker.
package axil_chk_pkg;

    localparam int ERR_W = 10;

    localparam int ERR_AW_STALL   = 0;
    localparam int ERR_W_STALL    = 1;
    localparam int ERR_AR_STALL   = 2;
    localparam int ERR_B_STALL    = 3;
    localparam int ERR_R_STALL    = 4;
    localparam int ERR_B_NO_PAIR  = 5;
    localparam int ERR_R_NO_OSTD  = 6;
    localparam int ERR_OVERFLOW   = 7;
    localparam int ERR_WR_TIMEOUT = 8;
    localparam int ERR_RD_TIMEOUT = 9;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [3:0] lowest_set(input logic [ERR_W-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = ERR_W - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axil_protocol_checker_if.sv
// AXI4-lite bundle; the monitor modport sees every signal as an input.
interface axil_protocol_checker_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport monitor (
        input awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready,
              bresp, bvalid, bready, araddr, arprot, arvalid, arready,
              rdata, rresp, rvalid, rready
    );
endinterface

// File: rtl/axil_chk_ostd_counter.sv
// Outstanding-transaction counter: saturates at MAX, holds at zero on underflow.
module axil_chk_ostd_counter #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         ovf,
    output logic         udf
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign ovf = inc && !dec && (count == MAX_V);
    assign udf = dec && !inc && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && (count != MAX_V)) begin
            count <= count + W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - W'(1);
        end
    end
endmodule

// File: rtl/axil_protocol_checker.sv
// Passive AXI4-lite protocol monitor with sticky violation flags.
// Define AXIL_CHK_TIMEOUT_EN to build the write/read response-latency timers.
module axil_protocol_checker
    import axil_chk_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int OUTSTAND_MAX   = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CNT_W         = $clog2(OUTSTAND_MAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    axil_protocol_checker_if.monitor   s_axil,
    input  logic                       err_clear,
    output logic [ERR_W-1:0]           err_flags,
    output logic                       err_valid,
    output logic [3:0]                 err_first,
    output logic [CNT_W-1:0]           aw_outstanding,
    output logic [CNT_W-1:0]           w_outstanding,
    output logic [CNT_W-1:0]           ar_outstanding
);
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_ovf, w_ovf, ar_ovf, aw_udf, w_udf, ar_udf;
    logic wr_tmo, rd_tmo;
    logic [ERR_W-1:0] new_err;
    logic             base_zero;

    logic                  aw_stall_q, w_stall_q, ar_stall_q, b_stall_q, r_stall_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [2:0]            aw_prot_q, ar_prot_q;
    logic [DATA_WIDTH-1:0] w_data_q, r_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic [1:0]            b_resp_q, r_resp_q;

    assign aw_hs = s_axil.awvalid && s_axil.awready;
    assign w_hs  = s_axil.wvalid  && s_axil.wready;
    assign b_hs  = s_axil.bvalid  && s_axil.bready;
    assign ar_hs = s_axil.arvalid && s_axil.arready;
    assign r_hs  = s_axil.rvalid  && s_axil.rready;

    axil_chk_ostd_counter #(.MAX(OUTSTAND_MAX), .W(CNT_W)) u_aw_cnt (
        .clk(clk), .rst(rst), .inc(aw_hs), .dec(b_hs),
        .count(aw_outstanding), .ovf(aw_ovf), .udf(aw_udf)
    );

    axil_chk_ostd_counter #(.MAX(OUTSTAND_MAX), .W(CNT_W)) u_w_cnt (
        .clk(clk), .rst(rst), .inc(w_hs), .dec(b_hs),
        .count(w_outstanding), .ovf(w_ovf), .udf(w_udf)
    );

    axil_chk_ostd_counter #(.MAX(OUTSTAND_MAX), .W(CNT_W)) u_ar_cnt (
        .clk(clk), .rst(rst), .inc(ar_hs), .dec(r_hs),
        .count(ar_outstanding), .ovf(ar_ovf), .udf(ar_udf)
    );

    // Payload is captured every cycle but only compared while the stall flag is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_stall_q <= 1'b0;
            w_stall_q  <= 1'b0;
            ar_stall_q <= 1'b0;
            b_stall_q  <= 1'b0;
            r_stall_q  <= 1'b0;
            aw_addr_q  <= '0;
            aw_prot_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            ar_addr_q  <= '0;
            ar_prot_q  <= '0;
            b_resp_q   <= '0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
        end else begin
            aw_stall_q <= s_axil.awvalid && !s_axil.awready;
            w_stall_q  <= s_axil.wvalid  && !s_axil.wready;
            ar_stall_q <= s_axil.arvalid && !s_axil.arready;
            b_stall_q  <= s_axil.bvalid  && !s_axil.bready;
            r_stall_q  <= s_axil.rvalid  && !s_axil.rready;
            aw_addr_q  <= s_axil.awaddr;
            aw_prot_q  <= s_axil.awprot;
            w_data_q   <= s_axil.wdata;
            w_strb_q   <= s_axil.wstrb;
            ar_addr_q  <= s_axil.araddr;
            ar_prot_q  <= s_axil.arprot;
            b_resp_q   <= s_axil.bresp;
            r_data_q   <= s_axil.rdata;
            r_resp_q   <= s_axil.rresp;
        end
    end

`ifdef AXIL_CHK_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMO_V = TMR_W'(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] wr_tmr, rd_tmr;
    logic             wr_fired, rd_fired;
    logic             wr_pend, rd_pend;

    assign wr_pend = (aw_outstanding != '0) && (w_outstanding != '0);
    assign rd_pend = (ar_outstanding != '0);

    // Timers hold at the limit; the fired bit makes each expiry report only once.
    assign wr_tmo = wr_pend && !b_hs && (wr_tmr == TMO_V) && !wr_fired;
    assign rd_tmo = rd_pend && !r_hs && (rd_tmr == TMO_V) && !rd_fired;

    always_ff @(posedge clk) begin
        if (rst || b_hs || !wr_pend) begin
            wr_tmr   <= '0;
            wr_fired <= 1'b0;
        end else begin
            if (wr_tmr != TMO_V) wr_tmr <= wr_tmr + TMR_W'(1);
            if (wr_tmo) wr_fired <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_hs || !rd_pend) begin
            rd_tmr   <= '0;
            rd_fired <= 1'b0;
        end else begin
            if (rd_tmr != TMO_V) rd_tmr <= rd_tmr + TMR_W'(1);
            if (rd_tmo) rd_fired <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign wr_tmo = 1'b0;
    assign rd_tmo = 1'b0;
`endif

    always_comb begin
        new_err = '0;
        new_err[ERR_AW_STALL] = aw_stall_q && (!s_axil.awvalid ||
                                s_axil.awaddr != aw_addr_q || s_axil.awprot != aw_prot_q);
        new_err[ERR_W_STALL]  = w_stall_q && (!s_axil.wvalid ||
                                s_axil.wdata != w_data_q || s_axil.wstrb != w_strb_q);
        new_err[ERR_AR_STALL] = ar_stall_q && (!s_axil.arvalid ||
                                s_axil.araddr != ar_addr_q || s_axil.arprot != ar_prot_q);
        new_err[ERR_B_STALL]  = b_stall_q && (!s_axil.bvalid || s_axil.bresp != b_resp_q);
        new_err[ERR_R_STALL]  = r_stall_q && (!s_axil.rvalid ||
                                s_axil.rdata != r_data_q || s_axil.rresp != r_resp_q);
        new_err[ERR_B_NO_PAIR] = (s_axil.bvalid && (aw_outstanding == '0 || w_outstanding == '0))
                                 || aw_udf || w_udf;
        new_err[ERR_R_NO_OSTD] = (s_axil.rvalid && ar_outstanding == '0) || ar_udf;
        new_err[ERR_OVERFLOW]  = aw_ovf || w_ovf || ar_ovf;
        new_err[ERR_WR_TIMEOUT] = wr_tmo;
        new_err[ERR_RD_TIMEOUT] = rd_tmo;
    end

    // A clear in the same cycle as a new violation still reports that violation.
    assign base_zero = err_clear || (err_flags == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_flags <= '0;
            err_valid <= 1'b0;
            err_first <= '0;
        end else begin
            err_valid <= 1'b0;
            if (err_clear) begin
                err_flags <= new_err;
                err_first <= '0;
            end else begin
                err_flags <= err_flags | new_err;
            end
            if (base_zero && (new_err != '0)) begin
                err_valid <= 1'b1;
                err_first <= lowest_set(new_err);
            end
        end
    end
endmodule
